// File: rtl/interval_timer.sv
// interval_timer: seconds countdown for the traffic FSM timer interface, programmable durations; EXPIRE_HOLD_EN holds expired until next start
module interval_timer #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int CNT_W         = 4,
   parameter int DEF_BASE      = 6,
   parameter int DEF_EXT       = 3,
   parameter int DEF_YEL       = 2
) (
   input  logic             clk,
   input  logic             Reset_n,
   input  logic             start_timer,
   input  logic [1:0]       interval,
   input  logic             Prog_Sync,
   input  logic [1:0]       Time_Param_Sel,
   input  logic [CNT_W-1:0] Time_Value,
   output logic             expired,
   output logic             busy,
   output logic [CNT_W-1:0] time_left
);
   localparam int PW = $clog2(TICKS_PER_SEC + 1);
   localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;
   logic [PW-1:0] presc;
   logic [CNT_W-1:0] t_base, t_ext, t_yel, sel_dur;
   logic tick, fin;
   assign tick    = state == RUN && presc == PMAX;
   assign fin     = tick && time_left <= CNT_W'(1) && !start_timer;
   assign sel_dur = interval == 2'b01 ? t_ext : interval == 2'b10 ? t_yel : t_base;
   assign busy    = state == RUN;
   // programmable durations; zero values and the unused select are dropped
   always_ff @(posedge clk or negedge Reset_n)
      if (!Reset_n) begin
         t_base <= CNT_W'(DEF_BASE);
         t_ext  <= CNT_W'(DEF_EXT);
         t_yel  <= CNT_W'(DEF_YEL);
      end else if (Prog_Sync && Time_Value != '0) begin
         if (Time_Param_Sel == 2'b00) t_base <= Time_Value;
         if (Time_Param_Sel == 2'b01) t_ext  <= Time_Value;
         if (Time_Param_Sel == 2'b10) t_yel  <= Time_Value;
      end
   // next state: start from anywhere wins over the final tick
   always_comb begin
      state_nx = state;
      if (start_timer) state_nx = RUN;
      else if (fin) state_nx = IDLE;
   end
   // state, prescaler, countdown and expiry flag
   always_ff @(posedge clk or negedge Reset_n)
      if (!Reset_n) begin
         state     <= IDLE;
         presc     <= '0;
         time_left <= '0;
         expired   <= 1'b0;
      end else begin
         state     <= state_nx;
         presc     <= (start_timer || tick || state != RUN) ? '0 : presc + PW'(1);
         time_left <= start_timer ? sel_dur : (tick && time_left != '0) ? time_left - CNT_W'(1) : time_left;
`ifdef EXPIRE_HOLD_EN
         expired   <= start_timer ? 1'b0 : fin ? 1'b1 : expired;
`else
         expired   <= fin;
`endif
      end
endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: scoreboard bench; stimulus queues expected expiry cycles, monitor checks them
module tb_interval_timer;
   logic clk = 0, Reset_n = 0, start_timer = 0, Prog_Sync = 0;
   logic [1:0] interval = 0, Time_Param_Sel = 0;
   logic [3:0] Time_Value = 0;
   logic expired, busy;
   logic [3:0] time_left;
   int cyc = 0, n_chk = 0, n_fail = 0, k = 0;
   int exp_q[$];
   logic prev_exp = 0;

   interval_timer #(.TICKS_PER_SEC(4), .CNT_W(4), .DEF_BASE(6), .DEF_EXT(3), .DEF_YEL(2)) dut (
      .clk(clk), .Reset_n(Reset_n), .start_timer(start_timer), .interval(interval),
      .Prog_Sync(Prog_Sync), .Time_Param_Sel(Time_Param_Sel), .Time_Value(Time_Value),
      .expired(expired), .busy(busy), .time_left(time_left));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // monitor: every expiry (rising edge in hold mode) must match the queue head
   always @(negedge clk) begin
`ifdef EXPIRE_HOLD_EN
      if (expired && !prev_exp) begin
`else
      if (expired) begin
`endif
         if (exp_q.size() == 0) chk("unexpected_expired", cyc, -1);
         else chk("expiry_cycle", cyc, exp_q.pop_front());
      end
      prev_exp <= expired;
   end

   task automatic step(input logic st, input logic [1:0] iv, input logic pg,
                       input logic [1:0] sel, input logic [3:0] val, output int edge_k);
      @(negedge clk);
      start_timer = st; interval = iv; Prog_Sync = pg; Time_Param_Sel = sel; Time_Value = val;
      @(posedge clk);
      #1;
      edge_k = cyc;
      start_timer = 0; Prog_Sync = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      idle(2);
      chk("rst_expired", expired, 0);
      chk("rst_busy", busy, 0);
      chk("rst_time_left", time_left, 0);
      @(negedge clk) Reset_n = 1;
      idle(2);
      // 1: base interval, 6 s
      step(1, 2'b00, 0, 0, 0, k);
      exp_q.push_back(k + 24);
      chk("t1_time_left", time_left, 6);
      chk("t1_busy", busy, 1);
      idle(4);
      chk("t1_after_tick", time_left, 5);
      idle(22);
      chk("t1_busy_done", busy, 0);
      chk("t1_time_left_done", time_left, 0);
      // 2: program yellow to 3
      step(0, 2'b00, 1, 2'b10, 4'd3, k);
      step(1, 2'b10, 0, 0, 0, k);
      exp_q.push_back(k + 12);
      chk("t2_time_left", time_left, 3);
      idle(16);
      // 3: restart during extended countdown
      step(1, 2'b01, 0, 0, 0, k);
      idle(7);
      step(1, 2'b00, 0, 0, 0, k);
      exp_q.push_back(k + 24);
      idle(28);
      // 4: zero value and select 11 ignored
      step(0, 2'b00, 1, 2'b00, 4'd0, k);
      step(0, 2'b00, 1, 2'b11, 4'd9, k);
      step(1, 2'b00, 0, 0, 0, k);
      chk("t4_base_kept", time_left, 6);
      exp_q.push_back(k + 24);
      idle(28);
      // start with simultaneous program loads the old base
      step(1, 2'b00, 1, 2'b00, 4'd5, k);
      chk("same_edge_old", time_left, 6);
      exp_q.push_back(k + 24);
      idle(28);
      step(1, 2'b00, 0, 0, 0, k);
      chk("new_base", time_left, 5);
      exp_q.push_back(k + 20);
      idle(24);
      // start on the final tick edge: no pulse, reload
      step(1, 2'b10, 0, 0, 0, k);
      idle(11);
      step(1, 2'b10, 0, 0, 0, k);
      chk("final_tick_reload", time_left, 3);
      exp_q.push_back(k + 12);
      idle(16);
      // start held high for 5 cycles
      for (int i = 0; i < 5; i++) step(1, 2'b01, 0, 0, 0, k);
      exp_q.push_back(k + 12);
      idle(16);
      // 5: reset mid-count
      step(1, 2'b00, 0, 0, 0, k);
      idle(9);
      @(negedge clk) Reset_n = 0;
      #1;
      chk("abort_expired", expired, 0);
      chk("abort_busy", busy, 0);
      chk("abort_time_left", time_left, 0);
      idle(2);
      @(negedge clk) Reset_n = 1;
      idle(30);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_time_left", time_left, 0);
      step(1, 2'b10, 0, 0, 0, k);
      chk("def_yel", time_left, 2);
      exp_q.push_back(k + 8);
      idle(12);
      step(1, 2'b00, 0, 0, 0, k);
      chk("def_base", time_left, 6);
      exp_q.push_back(k + 24);
      idle(20);
`ifdef EXPIRE_HOLD_EN
      idle(8);
      // 6: expired held until next start
      step(1, 2'b10, 0, 0, 0, k);
      exp_q.push_back(k + 8);
      idle(7);
      chk("hold_before", expired, 0);
      idle(1);
      chk("hold_set", expired, 1);
      idle(10);
      chk("hold_kept", expired, 1);
      step(1, 2'b00, 0, 0, 0, k);
      chk("hold_cleared", expired, 0);
      exp_q.push_back(k + 24);
      idle(28);
`else
      idle(8);
`endif
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: stuck at cycle %0d, required finish", cyc);
      $fatal(1);
   end
endmodule
